// File: rtl/in_port_fifo.sv
// Receive-side input port: device words enter a first-word-fall-through FIFO; the head word feeds the bus mux.
// Push is visible one edge after acceptance; one word is popped per InPortout strobe, at its falling edge. dev_ready drops when the FIFO is full.
module in_port_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int CW         = $clog2(DEPTH) + 1
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [DATA_WIDTH-1:0] dev_data,
  input  logic                  dev_valid,
  output logic                  dev_ready,
  input  logic                  InPortout,
  output logic [DATA_WIDTH-1:0] BusMuxIn_InPort,
  output logic                  in_empty,
  output logic                  in_full,
  output logic [CW-1:0]         in_count,
  output logic                  underflow
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wp_q, wp_d;
  logic [AW-1:0]         rp_q, rp_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  ip_q;
  logic                  underflow_q, underflow_d;
  logic                  push, pop;

  assign in_empty        = (count_q == '0);
  assign in_full         = (count_q == FULL_CNT);
  assign dev_ready       = !in_full;
  assign in_count        = count_q;
  assign underflow       = underflow_q;
  assign BusMuxIn_InPort = in_empty ? '0 : mem_q[rp_q];

  // A strobe is consumed only once, on the first edge after it drops.
  assign push = dev_valid && dev_ready;
  assign pop  = ip_q && !InPortout && !in_empty;

  always_comb begin
    wp_d        = wp_q;
    rp_d        = rp_q;
    count_d     = count_q;
    underflow_d = underflow_q || (InPortout && in_empty);
    if (push) wp_d = wp_q + AW'(1);
    if (pop)  rp_d = rp_q + AW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wp_q        <= '0;
      rp_q        <= '0;
      count_q     <= '0;
      ip_q        <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      count_q     <= count_d;
      ip_q        <= InPortout;
      underflow_q <= underflow_d;
    end
  end

  // Storage needs no reset: the head is masked to zero while the count is zero.
  always_ff @(posedge Clock) begin
    if (push) mem_q[wp_q] <= dev_data;
  end

endmodule

// File: tb/tb_in_port_fifo.sv
// Bench for in_port_fifo: directed scenarios plus random traffic, all checked against a queue-based model.
module tb_in_port_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          Clock = 1'b0;
  logic          Reset = 1'b0;
  logic [DW-1:0] dev_data = '0;
  logic          dev_valid = 1'b0;
  logic          dev_ready;
  logic          InPortout = 1'b0;
  logic [DW-1:0] BusMuxIn_InPort;
  logic          in_empty;
  logic          in_full;
  logic [CW-1:0] in_count;
  logic          underflow;

  in_port_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .Clock(Clock), .Reset(Reset),
    .dev_data(dev_data), .dev_valid(dev_valid), .dev_ready(dev_ready),
    .InPortout(InPortout), .BusMuxIn_InPort(BusMuxIn_InPort),
    .in_empty(in_empty), .in_full(in_full), .in_count(in_count),
    .underflow(underflow)
  );

  always #5 Clock = ~Clock;

  int n_total = 0;
  int n_pass  = 0;

  logic [DW-1:0] m_q[$];
  bit            m_ip;
  bit            m_uf;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_clear();
    m_q.delete();
    m_ip = 1'b0;
    m_uf = 1'b0;
  endtask

  // Reference behaviour: one edge of the FIFO expressed on a queue.
  task automatic model_step();
    bit was_empty, do_push, do_pop;
    was_empty = (m_q.size() == 0);
    do_push   = dev_valid && (m_q.size() < DEPTH);
    do_pop    = m_ip && !InPortout && !was_empty;
    if (InPortout && was_empty) m_uf = 1'b1;
    if (do_pop)  void'(m_q.pop_front());
    if (do_push) m_q.push_back(dev_data);
    m_ip = InPortout;
  endtask

  task automatic check_all(input string tag);
    logic [31:0] head;
    head = (m_q.size() == 0) ? 32'h0 : m_q[0];
    check_eq({tag, ".head"},  BusMuxIn_InPort, head);
    check_eq({tag, ".count"}, 32'(in_count), 32'(m_q.size()));
    check_eq({tag, ".empty"}, 32'(in_empty), 32'(m_q.size() == 0));
    check_eq({tag, ".full"},  32'(in_full), 32'(m_q.size() == DEPTH));
    check_eq({tag, ".ready"}, 32'(dev_ready), 32'(m_q.size() != DEPTH));
    check_eq({tag, ".uf"},    32'(underflow), 32'(m_uf));
  endtask

  task automatic cycle(input string tag);
    @(posedge Clock);
    if (Reset) model_step();
    #1;
    check_all(tag);
  endtask

  task automatic apply_reset();
    Reset = 1'b0;
    model_clear();
    #1;
    check_all("reset");
    @(negedge Clock);
    Reset = 1'b1;
  endtask

  task automatic push_word(input logic [31:0] w, input string tag);
    dev_valid = 1'b1;
    dev_data  = w;
    cycle(tag);
    dev_valid = 1'b0;
  endtask

  initial begin
    model_clear();
    #2;
    apply_reset();
    check_eq("rst_head", BusMuxIn_InPort, 32'h0);
    check_eq("rst_empty", 32'(in_empty), 32'd1);
    check_eq("rst_ready", 32'(dev_ready), 32'd1);

    // Single push is visible after one edge
    push_word(32'hA5A5_0001, "p1");
    check_eq("p1_head", BusMuxIn_InPort, 32'hA5A5_0001);
    check_eq("p1_count", 32'(in_count), 32'd1);
    check_eq("p1_empty", 32'(in_empty), 32'd0);
    check_eq("p1_ready", 32'(dev_ready), 32'd1);

    // Fill, stall a fifth word, release it with one strobe
    apply_reset();
    dev_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      dev_data = 32'h11 * i;
      cycle("fill");
    end
    check_eq("full_flag", 32'(in_full), 32'd1);
    check_eq("full_ready", 32'(dev_ready), 32'd0);
    check_eq("full_count", 32'(in_count), 32'd4);
    dev_data = 32'h55;
    cycle("stall");
    cycle("stall");
    check_eq("stall_count", 32'(in_count), 32'd4);
    InPortout = 1'b1;
    repeat (3) cycle("strobe3");
    InPortout = 1'b0;
    cycle("strobe3_fall");
    check_eq("fall_count", 32'(in_count), 32'd3);
    cycle("accept55");
    dev_valid = 1'b0;
    check_eq("acc_head", BusMuxIn_InPort, 32'h22);
    check_eq("acc_count", 32'(in_count), 32'd4);

    // Long strobe pops exactly once
    apply_reset();
    push_word(32'h11, "lp");
    push_word(32'h22, "lp");
    InPortout = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle("long");
      check_eq("long_head", BusMuxIn_InPort, 32'h11);
      check_eq("long_count", 32'(in_count), 32'd2);
    end
    InPortout = 1'b0;
    cycle("long_fall");
    check_eq("long_fall_count", 32'(in_count), 32'd1);
    check_eq("long_fall_head", BusMuxIn_InPort, 32'h22);
    cycle("long_after");
    check_eq("long_after_count", 32'(in_count), 32'd1);

    // Pop coincident with push, then pointer wrap
    push_word(32'h33, "pp");
    InPortout = 1'b1;
    cycle("pp_strobe");
    InPortout = 1'b0;
    push_word(32'h44, "pp_both");
    check_eq("pp_count", 32'(in_count), 32'd2);
    check_eq("pp_head", BusMuxIn_InPort, 32'h33);
    for (int k = 0; k < 8; k++) begin
      InPortout = 1'b1;
      cycle("wrap_hi");
      InPortout = 1'b0;
      push_word(32'd100 + 32'(k), "wrap_both");
      check_eq("wrap_count", 32'(in_count), 32'd2);
    end
    check_eq("wrap_head", BusMuxIn_InPort, 32'd106);

    // Underflow is sticky until reset
    apply_reset();
    InPortout = 1'b1;
    cycle("uf_strobe");
    check_eq("uf_set", 32'(underflow), 32'd1);
    check_eq("uf_head", BusMuxIn_InPort, 32'h0);
    InPortout = 1'b0;
    cycle("uf_fall");
    push_word(32'h7, "uf_push");
    cycle("uf_idle");
    cycle("uf_idle");
    check_eq("uf_kept", 32'(underflow), 32'd1);
    check_eq("uf_count", 32'(in_count), 32'd1);
    check_eq("uf_head7", BusMuxIn_InPort, 32'h7);
    apply_reset();
    check_eq("uf_cleared", 32'(underflow), 32'd0);

    // Reset in the middle of a strobe discards everything
    push_word(32'hA1, "mr");
    push_word(32'hA2, "mr");
    push_word(32'hA3, "mr");
    InPortout = 1'b1;
    cycle("mr_strobe");
    #2;
    Reset = 1'b0;
    model_clear();
    #1;
    check_eq("mr_count", 32'(in_count), 32'd0);
    check_eq("mr_empty", 32'(in_empty), 32'd1);
    @(negedge Clock);
    Reset = 1'b1;
    cycle("mr_hold");
    InPortout = 1'b0;
    cycle("mr_fall");
    check_eq("mr_fall_count", 32'(in_count), 32'd0);

    // Random traffic
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      dev_valid = ($urandom_range(0, 99) < 55);
      dev_data  = $urandom;
      if ($urandom_range(0, 3) == 0) InPortout = ~InPortout;
      cycle("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
